// File: rtl/token_sched_pkg.sv
// Shared constants and types for the token decimation scheduler.
// Holds default sizing, the ratio reset value and the channel id type.
package token_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int RATIO_W_DEF = 4;
    localparam int PEND_W_DEF  = 3;
    localparam int RATIO_RST   = 2;

    typedef logic [$clog2(N_CH_DEF)-1:0] ch_id_t;

endpackage

// File: rtl/token_decimator.sv
// One channel: programmable every-R-th-token decimator, pending counter
// and sticky overflow. Ports: a (token in), cfg_we_local/cfg_ratio
// (ratio write), grant (scheduler took one token), req (pending != 0),
// overflow (a decimated token was dropped at full pending).
module token_decimator
    import token_sched_pkg::*;
#(
    parameter int RATIO_W = RATIO_W_DEF,
    parameter int PEND_W  = PEND_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               cfg_we_local,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               grant,
    output logic               req,
    output logic               overflow
);

    logic [RATIO_W-1:0] r_ratio;
    logic [RATIO_W-1:0] r_phase;
    logic [PEND_W-1:0]  r_pend;
    logic               r_ovf;

    logic w_pass;
    logic w_last;
    logic w_tok;
    logic w_full;

    // Ratios 0 and 1 both pass every token through.
    assign w_pass = (r_ratio[RATIO_W-1:1] == '0);
    assign w_last = (r_phase == r_ratio - RATIO_W'(1));
    // A token colliding with a ratio write is discarded.
    assign w_tok  = a && !cfg_we_local && (w_pass || w_last);
    assign w_full = &r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ratio <= RATIO_W'(RATIO_RST);
            r_phase <= '0;
        end else if (cfg_we_local) begin
            r_ratio <= cfg_ratio;
            r_phase <= '0;
        end else if (a && !w_pass) begin
            r_phase <= w_last ? '0 : r_phase + RATIO_W'(1);
        end
    end

    // Grant only arrives while pending is non-zero, so no underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else if (w_tok && !grant) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_pend <= r_pend + PEND_W'(1);
            end
        end else if (!w_tok && grant) begin
            r_pend <= r_pend - PEND_W'(1);
        end
    end

    assign req      = (r_pend != '0);
    assign overflow = r_ovf;

endmodule

// File: rtl/token_decimation_scheduler.sv
// N_CH decimating token channels sharing one tagged serial output via a
// round-robin arbiter. Ports: a (token inputs), cfg_* (ratio write), b/b_id
// (scheduled token and its channel), overflow (sticky per-channel drop flag).
module token_decimation_scheduler
    import token_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int RATIO_W = RATIO_W_DEF,
    parameter int PEND_W  = PEND_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [RATIO_W-1:0]      cfg_ratio,
    output logic                    b,
    output logic [$clog2(N_CH)-1:0] b_id,
    output logic [N_CH-1:0]         overflow
);

    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_gnt;
    logic [N_CH-1:0] w_we;
    logic            w_any;
    logic [ID_W-1:0] w_gid;

    logic            r_b;
    logic [ID_W-1:0] r_bid;
    logic [ID_W-1:0] r_ptr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // An out-of-range cfg_ch matches no channel.
        assign w_we[i]  = cfg_we && (cfg_ch == ID_W'(i));
        assign w_gnt[i] = w_any && (w_gid == ID_W'(i));

        token_decimator #(
            .RATIO_W (RATIO_W),
            .PEND_W  (PEND_W)
        ) u_dec (
            .clk          (clk),
            .rst          (rst),
            .a            (a[i]),
            .cfg_we_local (w_we[i]),
            .cfg_ratio    (cfg_ratio),
            .grant        (w_gnt[i]),
            .req          (w_req[i]),
            .overflow     (overflow[i])
        );
    end

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_gid = '0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(r_ptr) + k) % N_CH;
            if (!w_any && w_req[ID_W'(idx)]) begin
                w_any = 1'b1;
                w_gid = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b   <= 1'b0;
            r_bid <= '0;
            r_ptr <= ID_W'(N_CH - 1);
        end else begin
            r_b   <= w_any;
            r_bid <= w_any ? w_gid : '0;
            if (w_any) begin
                r_ptr <= w_gid;
            end
        end
    end

    assign b    = r_b;
    assign b_id = r_bid;

endmodule

// File: tb/tb_token_decimation_scheduler.sv
// Randomized and directed bench for token_decimation_scheduler, checked
// against a token-counting reference model of the channel rules.
module tb_token_decimation_scheduler;

    localparam int N    = 4;
    localparam int PMAX = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   a;
    logic         cfg_we;
    logic [1:0]   cfg_ch;
    logic [3:0]   cfg_ratio;
    logic         b;
    logic [1:0]   b_id;
    logic [3:0]   overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulse;
    int n_pulse_ch [N];

    // reference state
    int m_ratio [N];
    int m_cnt   [N];
    int m_pend  [N];
    int m_ovf   [N];
    int m_ptr;
    int m_b;
    int m_id;

    token_decimation_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_ratio (cfg_ratio),
        .b         (b),
        .b_id      (b_id),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] ovf_vec();
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_ovf[i] != 0);
        return v;
    endfunction

    // One clock edge of the reference: tokens counted toward groups of R,
    // queued tokens served round-robin, one per cycle.
    task automatic model_edge(input logic [3:0] av, input logic we,
                              input int ch, input int rt, input logic rs);
        int gnt;
        int r;
        int tok;
        if (rs) begin
            for (int i = 0; i < N; i++) begin
                m_ratio[i] = 2; m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_ptr = N - 1; m_b = 0; m_id = 0;
            return;
        end
        gnt = -1;
        for (int k = 1; k <= N; k++) begin
            if (gnt < 0 && m_pend[(m_ptr + k) % N] > 0) gnt = (m_ptr + k) % N;
        end
        for (int i = 0; i < N; i++) begin
            tok = 0;
            if (we && ch == i) begin
                m_ratio[i] = rt;
                m_cnt[i]   = 0;
            end else if (av[i]) begin
                r = (m_ratio[i] < 2) ? 1 : m_ratio[i];
                m_cnt[i]++;
                if (m_cnt[i] >= r) begin
                    tok = 1;
                    m_cnt[i] = 0;
                end
            end
            if (tok == 1 && m_pend[i] == PMAX && gnt != i) m_ovf[i] = 1;
            else m_pend[i] = m_pend[i] + tok - ((gnt == i) ? 1 : 0);
        end
        m_b  = (gnt >= 0) ? 1 : 0;
        m_id = (gnt >= 0) ? gnt : 0;
        if (gnt >= 0) m_ptr = gnt;
    endtask

    task automatic step(input logic [3:0] av, input logic we,
                        input logic [1:0] ch, input logic [3:0] rt,
                        input logic rs);
        a = av; cfg_we = we; cfg_ch = ch; cfg_ratio = rt; rst = rs;
        @(posedge clk);
        model_edge(av, we, int'(ch), int'(rt), rs);
        #1;
        chk("b", 32'(b), 32'(m_b));
        chk("b_id", 32'(b_id), 32'(m_id));
        chk("overflow", 32'(overflow), 32'(ovf_vec()));
        if (b) begin
            n_pulse++;
            n_pulse_ch[b_id]++;
        end
    endtask

    task automatic tok(input logic [3:0] av);
        step(av, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tok(4'b0000);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [3:0] rt);
        step(4'b0000, 1'b1, ch, rt, 1'b0);
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 2'd0, 4'd0, 1'b1);
    endtask

    task automatic clr_cnt();
        n_pulse = 0;
        for (int i = 0; i < N; i++) n_pulse_ch[i] = 0;
    endtask

    initial begin
        logic [15:0] pat;
        logic [1:0]  ids [4];
        a = '0; cfg_we = 0; cfg_ch = '0; cfg_ratio = '0; rst = 1;

        do_reset();
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // default halving on ch0
        clr_cnt();
        pat = 16'b1100_1110_1000_1111;
        for (int i = 15; i >= 0; i--) tok({3'b000, pat[i]});
        idle(4);
        chk("halving_pulses", 32'(n_pulse_ch[0]), 32'd5);

        // ratio 3 on ch1, nine tokens
        clr_cnt();
        cfg(2'd1, 4'd3);
        for (int i = 0; i < 9; i++) tok(4'b0010);
        idle(4);
        chk("ratio3_pulses", 32'(n_pulse_ch[1]), 32'd3);

        // ratio 0 on ch2, four tokens
        clr_cnt();
        cfg(2'd2, 4'd0);
        for (int i = 0; i < 4; i++) tok(4'b0100);
        idle(4);
        chk("ratio0_pulses", 32'(n_pulse_ch[2]), 32'd4);

        // round-robin from a fresh pointer
        do_reset();
        for (int c = 0; c < N; c++) cfg(2'(c), 4'd1);
        tok(4'b1111);
        tok(4'b0000);
        for (int i = 0; i < 4; i++) begin
            ids[i] = b_id;
            chk("rr_b", 32'(b), 32'd1);
            if (i < 3) tok(4'b0000);
        end
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(ids[i]), 32'(i));
        idle(2);

        // saturation with all channels flooding
        clr_cnt();
        for (int i = 0; i < 12; i++) tok(4'b1111);
        chk("sat_ovf3", 32'(overflow[3]), 32'd1);
        idle(40);
        chk("sat_pend_drained", 32'(b), 32'd0);

        // config collision on ch0
        do_reset();
        clr_cnt();
        tok(4'b0001);
        step(4'b0001, 1'b1, 2'd0, 4'd2, 1'b0);
        idle(4);
        chk("collide_none", 32'(n_pulse), 32'd0);
        tok(4'b0001);
        tok(4'b0001);
        idle(4);
        chk("collide_one", 32'(n_pulse), 32'd1);

        // reset mid-operation with pending tokens and b high
        cfg(2'd0, 4'd1);
        cfg(2'd1, 4'd1);
        for (int i = 0; i < 4; i++) tok(4'b0011);
        do_reset();
        clr_cnt();
        idle(6);
        chk("post_rst_quiet", 32'(n_pulse), 32'd0);

        // randomized traffic and config
        for (int i = 0; i < 400; i++) begin
            logic [3:0] av;
            av = 4'($urandom);
            if ($urandom_range(0, 99) < 2)
                step(av, 1'b0, 2'd0, 4'd0, 1'b1);
            else if ($urandom_range(0, 9) == 0)
                step(av, 1'b1, 2'($urandom), 4'($urandom), 1'b0);
            else
                tok(av & 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
